// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss block-fill engine between the I/D cache arrays
// and pipelined main memory.
//
// On a miss it issues one read per word of the block on consecutive cycles,
// writes each returned word into the data array, and writes the tag together
// with the last word. fsm_busy stalls the pipeline for the whole fill.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous active-high reset
//   miss_detected       cache missed; held until fsm_busy falls
//   miss_address        byte address that missed
//   memory_data_valid   memory_data carries a returned word
//   memory_data         returned word, in request order
//   fsm_busy            fill in progress (pipeline stall)
//   memory_read         read request this cycle
//   memory_address      address of the read request
//   write_data_array    write cache_write_data this cycle
//   cache_write_address byte address of the word being written
//   cache_write_data    word being written (memory_data passthrough)
//   write_tag_array     write tag/valid for the block this cycle
//
// Optional build macro:
//   CRITICAL_WORD_FIRST_EN  requests and writes wrap around starting at the
//                           missed word instead of word 0.

module cache_fill_fsm #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              memory_read,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] cache_write_address,
    output logic [DATA_W-1:0] cache_write_data,
    output logic              write_tag_array
);

    // Word index width, byte offset width inside a block, counter width.
    localparam int WIDX  = $clog2(BLOCK_WORDS);
    localparam int OFF_W = WIDX + 1;
    localparam int CNT_W = WIDX + 1;
    localparam int HI_W  = ADDR_W - OFF_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state;
    state_t            state_next;

    // Only the block-number bits of the base are stored; the low offset
    // bits of an aligned base are always zero.
    logic [HI_W-1:0]   base_hi;
    logic [HI_W-1:0]   base_hi_next;
    logic [CNT_W-1:0]  tx_cnt;
    logic [CNT_W-1:0]  tx_cnt_next;
    logic [CNT_W-1:0]  rx_cnt;
    logic [CNT_W-1:0]  rx_cnt_next;

    logic [HI_W-1:0]   miss_hi;
    logic [WIDX-1:0]   first_word;
    logic [WIDX-1:0]   tx_word;
    logic [WIDX-1:0]   rx_word;

    assign miss_hi = miss_address[ADDR_W-1:OFF_W];

`ifdef CRITICAL_WORD_FIRST_EN
    logic [WIDX-1:0]   crit_w;
    logic [WIDX-1:0]   crit_w_next;

    // Index arithmetic is WIDX bits wide, so the wrap-around inside the
    // block is just natural truncation.
    assign first_word = miss_address[OFF_W-1:1];
    assign tx_word    = crit_w + tx_cnt[WIDX-1:0];
    assign rx_word    = crit_w + rx_cnt[WIDX-1:0];

    logic unused_bits;
    assign unused_bits = miss_address[0];
`else
    assign first_word = '0;
    assign tx_word    = tx_cnt[WIDX-1:0];
    assign rx_word    = rx_cnt[WIDX-1:0];

    logic unused_bits;
    assign unused_bits = ^miss_address[OFF_W-1:0];
`endif

    // Aligned base plus 2*index: concatenation, no carry out of the block.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [HI_W-1:0] hi,
        input logic [WIDX-1:0] idx
    );
        return {hi, idx, 1'b0};
    endfunction

    always_comb begin
        state_next          = state;
        base_hi_next        = base_hi;
        tx_cnt_next         = tx_cnt;
        rx_cnt_next         = rx_cnt;
`ifdef CRITICAL_WORD_FIRST_EN
        crit_w_next         = crit_w;
`endif
        fsm_busy            = 1'b0;
        memory_read         = 1'b0;
        memory_address      = '0;
        write_data_array    = 1'b0;
        cache_write_address = '0;
        cache_write_data    = '0;
        write_tag_array     = 1'b0;

        // Reset wins over everything in its cycle, including a completing
        // return, so a reset never leaves a half-filled block tagged valid.
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (miss_detected) begin
                        fsm_busy       = 1'b1;
                        memory_read    = 1'b1;
                        memory_address = word_addr(miss_hi, first_word);
                        base_hi_next   = miss_hi;
                        tx_cnt_next    = CNT_W'(1);
                        rx_cnt_next    = '0;
`ifdef CRITICAL_WORD_FIRST_EN
                        crit_w_next    = first_word;
`endif
                        state_next     = FILL;
                    end
                end

                FILL: begin
                    fsm_busy = 1'b1;

                    if (tx_cnt < CNT_FULL) begin
                        memory_read    = 1'b1;
                        memory_address = word_addr(base_hi, tx_word);
                        tx_cnt_next    = tx_cnt + CNT_W'(1);
                    end

                    if (memory_data_valid) begin
                        write_data_array    = 1'b1;
                        cache_write_address = word_addr(base_hi, rx_word);
                        cache_write_data    = memory_data;
                        rx_cnt_next         = rx_cnt + CNT_W'(1);
                        if (rx_cnt == CNT_LAST) begin
                            write_tag_array = 1'b1;
                            state_next      = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base_hi <= '0;
            tx_cnt  <= '0;
            rx_cnt  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            crit_w  <= '0;
`endif
        end else begin
            state   <= state_next;
            base_hi <= base_hi_next;
            tx_cnt  <= tx_cnt_next;
            rx_cnt  <= rx_cnt_next;
`ifdef CRITICAL_WORD_FIRST_EN
            crit_w  <= crit_w_next;
`endif
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench for cache_fill_fsm with a latency-4
// pipelined memory model and a block-level reference of each fill.

module tb_cache_fill_fsm;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int BW  = 8;
    localparam int LAT = 4;
    localparam int DUR = LAT + BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic          memory_data_valid;
    logic [DW-1:0] memory_data;
    logic          fsm_busy;
    logic          memory_read;
    logic [AW-1:0] memory_address;
    logic          write_data_array;
    logic [AW-1:0] cache_write_address;
    logic [DW-1:0] cache_write_data;
    logic          write_tag_array;

    cache_fill_fsm #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .BLOCK_WORDS(BW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .miss_detected      (miss_detected),
        .miss_address       (miss_address),
        .memory_data_valid  (memory_data_valid),
        .memory_data        (memory_data),
        .fsm_busy           (fsm_busy),
        .memory_read        (memory_read),
        .memory_address     (memory_address),
        .write_data_array   (write_data_array),
        .cache_write_address(cache_write_address),
        .cache_write_data   (cache_write_data),
        .write_tag_array    (write_tag_array)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
        logic        tag;
    } ev_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } mem_t;

    ev_t  reqq[$];
    ev_t  wrq[$];
    mem_t memq[$];

    int   cyc     = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   mon_en  = 0;
    bit   spur    = 0;
    int   n_vec   = 0;
    int   n_err   = 0;

    // Content of main memory at a given address.
    function automatic logic [15:0] mdata(input logic [15:0] a);
        return (a ^ 16'hA5C3) + {a[7:0], a[15:8]};
    endfunction

    // Advance one cycle; drive memory returns that are due, otherwise an
    // optional spurious valid.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        while (memq.size() > 0 && memq[0].due < cyc)
            void'(memq.pop_front());
        if (memq.size() > 0 && memq[0].due == cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = memq[0].data;
            void'(memq.pop_front());
        end else begin
            memory_data_valid = spur;
            memory_data       = 16'hBEEF;
        end
    endtask

    // Reference: the whole fill's expected traffic from the block rules.
    task automatic expect_fill(input logic [15:0] a, input int c);
        logic [15:0] base;
        int          w;
        ev_t         e;
        base = a & 16'hFFF0;
`ifdef CRITICAL_WORD_FIRST_EN
        w = int'(a[3:1]);
`else
        w = 0;
`endif
        for (int i = 0; i < BW; i++) begin
            e.addr = base + 16'(2 * ((w + i) % BW));
            e.data = mdata(e.addr);
            e.cyc  = c + i;
            e.tag  = 1'b0;
            reqq.push_back(e);
            e.cyc  = c + LAT + i;
            e.tag  = (i == BW - 1);
            wrq.push_back(e);
        end
        busy_lo = c;
        busy_hi = c + DUR - 1;
    endtask

    task automatic purge(input int r);
        for (int i = reqq.size() - 1; i >= 0; i--)
            if (reqq[i].cyc >= r) reqq.delete(i);
        for (int i = wrq.size() - 1; i >= 0; i--)
            if (wrq[i].cyc >= r) wrq.delete(i);
        if (busy_hi >= r) busy_hi = r - 1;
    endtask

    task automatic drain();
        int g = 0;
        while (memq.size() > 0 && g < 40) begin
            tick();
            g++;
        end
    endtask

    // Starts a miss in the current cycle; rk>0 resets at fill cycle rk.
    // Returns in the completion cycle (or after the reset drained).
    task automatic run_fill(input logic [15:0] a, input int rk);
        spur          = 1'b0;
        miss_detected = 1'b1;
        miss_address  = a;
        expect_fill(a, cyc);
        for (int k = 1; k < DUR; k++) begin
            tick();
            miss_address = 16'($urandom);
            if (k == rk) begin
                rst           = 1'b1;
                miss_detected = 1'b0;
                purge(cyc);
                tick();
                rst = 1'b0;
                drain();
                return;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (fsm_busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
                n_err++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, fsm_busy,
                         (cyc >= busy_lo && cyc <= busy_hi));
            end

            while (reqq.size() > 0 && reqq[0].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL req_missing cyc=%0d got=none exp=%h",
                         cyc, reqq[0].addr);
                void'(reqq.pop_front());
            end
            if (memory_read === 1'b1) begin
                memq.push_back('{cyc + LAT, mdata(memory_address)});
                n_vec++;
                if (reqq.size() == 0 || reqq[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL req_unexpected cyc=%0d got=%h exp=none",
                             cyc, memory_address);
                end else begin
                    if (memory_address !== reqq[0].addr) begin
                        n_err++;
                        $display("FAIL req_addr cyc=%0d got=%h exp=%h",
                                 cyc, memory_address, reqq[0].addr);
                    end
                    void'(reqq.pop_front());
                end
            end else if (reqq.size() > 0 && reqq[0].cyc == cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL req_missing cyc=%0d got=none exp=%h",
                         cyc, reqq[0].addr);
                void'(reqq.pop_front());
            end

            if (write_data_array === 1'b1) begin
                n_vec++;
                if (wrq.size() == 0 || wrq[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL wr_unexpected cyc=%0d got=%h exp=none",
                             cyc, cache_write_address);
                end else begin
                    if (cache_write_address !== wrq[0].addr ||
                        cache_write_data !== wrq[0].data ||
                        write_tag_array !== wrq[0].tag) begin
                        n_err++;
                        $display("FAIL wr cyc=%0d got=%h/%h/%b exp=%h/%h/%b",
                                 cyc, cache_write_address, cache_write_data,
                                 write_tag_array, wrq[0].addr, wrq[0].data,
                                 wrq[0].tag);
                    end
                    void'(wrq.pop_front());
                end
            end else begin
                if (wrq.size() > 0 && wrq[0].cyc <= cyc) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wr_missing cyc=%0d got=none exp=%h",
                             cyc, wrq[0].addr);
                    void'(wrq.pop_front());
                end
                if (write_tag_array !== 1'b0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tag_no_write cyc=%0d got=%b exp=0",
                             cyc, write_tag_array);
                end
            end
        end
    end

    initial begin
        int rk;
        int gap;
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = '0;
        memory_data_valid = 1'b0;
        memory_data       = '0;
        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // Spurious returns while idle.
        spur = 1'b1;
        repeat (3) tick();
        spur = 1'b0;
        tick();

        run_fill(16'h1236, 0);
        tick();
        miss_detected = 1'b0;
        repeat (2) tick();

        run_fill(16'hFFFE, 0);
        tick();
        miss_detected = 1'b0;
        tick();

        run_fill(16'h0040, 6);
        tick();

        // Back-to-back fills with no idle gap.
        run_fill(16'h0080, 0);
        tick();
        run_fill(16'h2000, 0);
        tick();
        miss_detected = 1'b0;
        repeat (2) tick();

        for (int n = 0; n < 150; n++) begin
            rk = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DUR - 1) : 0;
            run_fill(16'($urandom), rk);
            tick();
            if (rk == 0 && $urandom_range(0, 2) == 0) continue;
            miss_detected = 1'b0;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                spur = 1'($urandom_range(0, 1));
                tick();
            end
            spur = 1'b0;
        end

        miss_detected = 1'b0;
        spur          = 1'b0;
        repeat (10) tick();

        n_vec++;
        if (reqq.size() != 0 || wrq.size() != 0) begin
            n_err++;
            $display("FAIL leftover got=%0d/%0d exp=0/0",
                     reqq.size(), wrq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling engine between the pipeline's cache arrays (I-side fetch and D-side MEM stage) and the multi-cycle, pipelined main memory.
- On a cache miss it issues one read per word of the 16-byte block on consecutive cycles, writes each returned word into the data array, and writes the tag on the last word.
- Holds fsm_busy high for the whole fill; the pipeline uses it as a stall source.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.
- BLOCK_WORDS, 8, words per cache block (power of 2; block bytes = 2*BLOCK_WORDS).

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- miss_detected  input  1  cache lookup missed this cycle; held by cache until fsm_busy falls.
- miss_address  input  ADDR_W  byte address that missed.
- memory_data_valid  input  1  memory_data carries a returned word this cycle.
- memory_data  input  DATA_W  word returned by main memory, in request order.
- fsm_busy  output  1  fill in progress; stall request to pipeline.
- memory_read  output  1  read request to main memory this cycle.
- memory_address  output  ADDR_W  address of current read request.
- write_data_array  output  1  write memory_data into data array this cycle.
- cache_write_address  output  ADDR_W  byte address of word being written.
- cache_write_data  output  DATA_W  word being written (memory_data passthrough).
- write_tag_array  output  1  write tag/valid for the block this cycle.

Behaviour:
- Block base = miss_address with low log2(2*BLOCK_WORDS) bits cleared (bits [3:0] at default).
- State:
  - States IDLE, FILL. Registers: state, base, tx_cnt and rx_cnt (each log2(BLOCK_WORDS)+1 bits).
  - Reset: state=IDLE, counters=0, base=0.
  - All outputs 0 in IDLE without miss.
- IDLE:
  - If miss_detected: this same cycle drive memory_read=1 and memory_address=block base (word 0).
  - Latch base, tx_cnt<=1, rx_cnt<=0, next state FILL.
  - fsm_busy=1 combinationally in this cycle.
- FILL, requests:
  - While tx_cnt<BLOCK_WORDS: memory_read=1, memory_address=base+2*tx_cnt, tx_cnt increments.
  - Requests occupy exactly BLOCK_WORDS consecutive cycles; memory_read then stays 0.
- FILL, returns:
  - Each cycle with memory_data_valid=1: write_data_array=1, cache_write_address=base+2*rx_cnt, cache_write_data=memory_data, rx_cnt increments.
  - Returns may overlap the request phase.
- Completion:
  - On the valid with rx_cnt==BLOCK_WORDS-1: write_tag_array=1 in that same cycle; next state IDLE.
  - fsm_busy=0 from the following cycle.
- Address arithmetic wraps modulo 2^ADDR_W; the base is aligned, so no intra-block carry occurs.
- Boundaries:
  - memory_data_valid in IDLE is ignored: no writes.
  - miss_detected during FILL is ignored; a new fill starts only from IDLE.
  - Miss re-asserted in the first IDLE cycle after completion starts a new fill immediately: back-to-back fills with a 0-cycle gap.
  - rst mid-fill: state IDLE next cycle, counters cleared, no tag write; a partial block stays invalid because its tag was never written.
  - Valid and completion in the same cycle as rst: rst wins, no write_tag_array.
- Latency:
  - With main-memory latency L (4 in the system), miss at cycle 0 gives data writes at cycles L..L+BLOCK_WORDS-1 and the tag at cycle L+BLOCK_WORDS-1.
  - fsm_busy is high for cycles 0..L+BLOCK_WORDS-1.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- When defined:
  - Requests wrap-around starting at the missed word w = miss_address[3:1].
  - Request i goes to base+2*((w+i) mod BLOCK_WORDS); return j is written to base+2*((w+j) mod BLOCK_WORDS).
  - The latched w is cleared on rst.
  - Tag write remains on the BLOCK_WORDS-th return.
- When undefined: strict ascending order from word 0 as above; w is not stored.

Test Plan:
- Memory model latency 4. Miss at cycle 0, miss_address=0x1236 -> memory_address 0x1230,0x1232,...,0x123E on cycles 0-7; cache writes at same addresses on cycles 4-11; write_tag_array only at cycle 11; fsm_busy high cycles 0-11, low at 12.
- With CRITICAL_WORD_FIRST_EN, miss_address=0x1236 -> request and write order 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234; tag at 8th return.
- Spurious memory_data_valid=1, memory_data=0xBEEF while IDLE -> write_data_array=0, write_tag_array=0, fsm_busy=0.
- rst asserted at cycle 6 of a fill at 0x0040 -> cycle 7: fsm_busy=0 and memory_read=0; no write_tag_array ever; a new miss at 0x0080 then requests from 0x0080.
- Miss at 0xFFFE -> base 0xFFF0, last request 0xFFFE, no wrap to 0x0000.
- Back-to-back: miss held and re-presented as 0x2000 immediately after first fill completes -> memory_read for 0x2000 in the first cycle fsm_busy would drop; fsm_busy stays high continuously.
